// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared types and constants for the data-memory arbiter. Holds
//            the FSM state encoding, the owner encoding, the RAM write-width
//            codes and the maximum supported wait-state count.
// Revision : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    // Write-width codes shared by the CPU port and the RAM port
    localparam logic [1:0] c_ww_64 = 2'd0;
    localparam logic [1:0] c_ww_32 = 2'd1;
    localparam logic [1:0] c_ww_16 = 2'd2;
    localparam logic [1:0] c_ww_8  = 2'd3;

    // The wait-state counter is 4 bits wide, so 15 is the largest legal value
    localparam int c_wait_states_max = 15;

endpackage
`default_nettype wire

// File: rtl/dmem_align_chk.sv
`default_nettype none
// ============================================================================
// Module   : dmem_align_chk
// Purpose  : Combinational alignment checker. Flags an address whose low bits
//            are not aligned to the natural size of the requested width.
// Ports    : i_addr_lo    [2:0] low address bits
//            i_width      [1:0] width code (0=64b, 1=32b, 2=16b, 3=8b)
//            o_misaligned       1 when the address is not naturally aligned
// Revision : 1.0  initial release
// ============================================================================
module dmem_align_chk
    import dmem_arbiter_pkg::*;
(
    input  logic [2:0] i_addr_lo,
    input  logic [1:0] i_width,
    output logic       o_misaligned
);

    always_comb begin
        o_misaligned = 1'b0;
        case (i_width)
            c_ww_64: o_misaligned = |i_addr_lo;
            c_ww_32: o_misaligned = |i_addr_lo[1:0];
            c_ww_16: o_misaligned = i_addr_lo[0];
            default: o_misaligned = 1'b0;   // byte accesses are always aligned
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Arbitrates a single-port data RAM between the CPU and a debug
//            port. One access at a time: IDLE -> ACCESS (WAIT_STATES+1 cycles
//            with ram_cs high) -> RESP (read data captured) -> IDLE, where the
//            completion pulse of the owner is high and a new grant may occur.
//            Debug wins only while dbg_halt is high.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            cpu_*                    CPU request/response port
//            dbg_*                    debug request/response port
//            ram_*                    RAM side (ram_rdata valid one cycle
//                                     after a ram_cs cycle)
//            cpu_misalign             only with DMEM_ARB_ALIGN_CHECK_EN
// Config   : DMEM_ARB_ALIGN_CHECK_EN  misaligned CPU requests skip the RAM
//                                     and complete with cpu_misalign
// Note     : a requester must drop its strobe in the cycle its completion
//            pulse is high, otherwise a new access is started.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [63:0]       cpu_wdata,
    output logic [63:0]       cpu_rdata,
    input  logic [1:0]        cpu_write_width,
    input  logic              cpu_rstrobe,
    input  logic              cpu_wstrobe,
    output logic              cpu_cycle_complete,

    input  logic              dbg_halt,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [63:0]       dbg_wdata,
    output logic [63:0]       dbg_rdata,
    input  logic              dbg_ce,
    input  logic              dbg_we,
    output logic              dbg_ready,

    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [63:0]       ram_wdata,
    output logic [1:0]        ram_write_width,
    input  logic [63:0]       ram_rdata
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    ,
    output logic              cpu_misalign
`endif
);

    state_t     r_state;
    owner_t     r_owner;
    logic [3:0] r_cnt;
    logic       r_we;       // latched direction of the current access
    logic       r_misal;    // current CPU request was rejected as misaligned

    logic       w_cpu_req;
    logic       w_dbg_req;
    logic       w_cpu_misal;

    assign w_cpu_req = cpu_rstrobe | cpu_wstrobe;
    assign w_dbg_req = dbg_halt & dbg_ce;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    dmem_align_chk u_align_chk (
        .i_addr_lo    (cpu_addr[2:0]),
        .i_width      (cpu_write_width),
        .o_misaligned (w_cpu_misal)
    );
`else
    assign w_cpu_misal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= ST_IDLE;
            r_owner            <= OWN_CPU;
            r_cnt              <= 4'd0;
            r_we               <= 1'b0;
            r_misal            <= 1'b0;
            ram_cs             <= 1'b0;
            ram_we             <= 1'b0;
            ram_addr           <= '0;
            ram_wdata          <= 64'd0;
            ram_write_width    <= c_ww_64;
            cpu_rdata          <= 64'd0;
            dbg_rdata          <= 64'd0;
            cpu_cycle_complete <= 1'b0;
            dbg_ready          <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            cpu_misalign       <= 1'b0;
`endif
        end else begin
            // Completion flags are single-cycle pulses
            cpu_cycle_complete <= 1'b0;
            dbg_ready          <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            cpu_misalign       <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_dbg_req) begin
                        // Debug accesses are always full 64-bit
                        r_owner         <= OWN_DBG;
                        r_we            <= dbg_we;
                        r_misal         <= 1'b0;
                        r_cnt           <= 4'(WAIT_STATES);
                        ram_addr        <= dbg_addr;
                        ram_wdata       <= dbg_wdata;
                        ram_write_width <= c_ww_64;
                        ram_cs          <= 1'b1;
                        ram_we          <= dbg_we;
                        r_state         <= ST_ACCESS;
                    end else if (w_cpu_req) begin
                        // Write strobe dominates when both strobes are high
                        r_owner         <= OWN_CPU;
                        r_we            <= cpu_wstrobe;
                        r_misal         <= w_cpu_misal;
                        r_cnt           <= 4'(WAIT_STATES);
                        ram_addr        <= cpu_addr;
                        ram_wdata       <= cpu_wdata;
                        ram_write_width <= cpu_write_width;
                        if (w_cpu_misal) begin
                            r_state <= ST_RESP;     // never touches the RAM
                        end else begin
                            ram_cs  <= 1'b1;
                            ram_we  <= cpu_wstrobe;
                            r_state <= ST_ACCESS;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        ram_cs  <= 1'b0;
                        ram_we  <= 1'b0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_RESP: begin
                    // ram_rdata now reflects the last ram_cs cycle
                    r_state <= ST_IDLE;
                    if (r_owner == OWN_DBG) begin
                        dbg_ready <= 1'b1;
                        if (!r_we) begin
                            dbg_rdata <= ram_rdata;
                        end
                    end else begin
                        cpu_cycle_complete <= 1'b1;
                        if (r_misal) begin
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                            cpu_misalign <= 1'b1;
`endif
                        end else if (!r_we) begin
                            cpu_rdata <= ram_rdata;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter. Two instances
//            share the request inputs: u_dut0 (WAIT_STATES=0) and u_dut2
//            (WAIT_STATES=2); sel2 selects which one the checks observe.
//            Each test starts from reset. Cycle index i counts negedges after
//            the grant cycle (the cycle the request is first presented).
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic [63:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [1:0]  cpu_write_width;
    logic        cpu_rstrobe, cpu_wstrobe, dbg_halt, dbg_ce, dbg_we;

    logic [63:0] cpu_rdata0, dbg_rdata0, ram_addr0, ram_wdata0, ram_rdata0;
    logic [63:0] cpu_rdata2, dbg_rdata2, ram_addr2, ram_wdata2, ram_rdata2;
    logic [1:0]  ram_ww0, ram_ww2;
    logic        cc0, dr0, cs0, we0, cc2, dr2, cs2, we2;
    logic        mis0, mis2;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter #(.WAIT_STATES(0), .ADDR_W(64)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0),
        .cpu_write_width(cpu_write_width), .cpu_rstrobe(cpu_rstrobe),
        .cpu_wstrobe(cpu_wstrobe), .cpu_cycle_complete(cc0),
        .dbg_halt(dbg_halt), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata0), .dbg_ce(dbg_ce), .dbg_we(dbg_we), .dbg_ready(dr0),
        .ram_cs(cs0), .ram_we(we0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .ram_write_width(ram_ww0), .ram_rdata(ram_rdata0)
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        , .cpu_misalign(mis0)
`endif
    );

    dmem_arbiter #(.WAIT_STATES(2), .ADDR_W(64)) u_dut2 (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata2),
        .cpu_write_width(cpu_write_width), .cpu_rstrobe(cpu_rstrobe),
        .cpu_wstrobe(cpu_wstrobe), .cpu_cycle_complete(cc2),
        .dbg_halt(dbg_halt), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata2), .dbg_ce(dbg_ce), .dbg_we(dbg_we), .dbg_ready(dr2),
        .ram_cs(cs2), .ram_we(we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .ram_write_width(ram_ww2), .ram_rdata(ram_rdata2)
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        , .cpu_misalign(mis2)
`endif
    );

`ifndef DMEM_ARB_ALIGN_CHECK_EN
    assign mis0 = 1'b0;
    assign mis2 = 1'b0;
`endif

    // RAM model: data appears one cycle after any cs cycle (also on writes,
    // so a wrongly captured write response is visible)
    function automatic logic [63:0] ram_val(input logic [63:0] a);
        if (a == 64'h10) return 64'hDEADBEEF_CAFEF00D;
        return {32'h1234_5678, a[31:0]};
    endfunction

    always @(posedge clk) begin
        ram_rdata0 <= cs0 ? ram_val(ram_addr0) : 64'd0;
        ram_rdata2 <= cs2 ? ram_val(ram_addr2) : 64'd0;
    end

    // Observation mux
    logic        sel2;
    logic        m_cs, m_we, m_cc, m_dr, m_mis;
    logic [63:0] m_addr, m_wdata, m_crd, m_drd;
    logic [1:0]  m_ww;
    assign m_cs    = sel2 ? cs2 : cs0;
    assign m_we    = sel2 ? we2 : we0;
    assign m_cc    = sel2 ? cc2 : cc0;
    assign m_dr    = sel2 ? dr2 : dr0;
    assign m_mis   = sel2 ? mis2 : mis0;
    assign m_addr  = sel2 ? ram_addr2 : ram_addr0;
    assign m_wdata = sel2 ? ram_wdata2 : ram_wdata0;
    assign m_crd   = sel2 ? cpu_rdata2 : cpu_rdata0;
    assign m_drd   = sel2 ? dbg_rdata2 : dbg_rdata0;
    assign m_ww    = sel2 ? ram_ww2 : ram_ww0;

    // Activity recorded by run()
    int          cs_cnt, we_cnt, cc_cnt, dr_cnt, mis_cnt, cc_cyc, dr_cyc, mis_cyc;
    logic [63:0] cs_addr, cs_wdata;
    logic [1:0]  cs_ww;

    task automatic do_reset(input logic s);
        @(negedge clk);
        sel2 = s; rst = 1'b1;
        cpu_addr = 64'd0; cpu_wdata = 64'd0; cpu_write_width = 2'd0;
        cpu_rstrobe = 1'b0; cpu_wstrobe = 1'b0;
        dbg_halt = 1'b0; dbg_addr = 64'd0; dbg_wdata = 64'd0; dbg_ce = 1'b0; dbg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded observation window; optionally drops a requester's strobe in
    // the cycle its completion pulse is seen.
    task automatic run(input int ncyc, input bit auto_drop);
        cs_cnt = 0; we_cnt = 0; cc_cnt = 0; dr_cnt = 0; mis_cnt = 0;
        cc_cyc = 0; dr_cyc = 0; mis_cyc = 0;
        cs_addr = 64'd0; cs_wdata = 64'd0; cs_ww = 2'd0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (m_cs) begin
                if (cs_cnt == 0) begin cs_addr = m_addr; cs_wdata = m_wdata; cs_ww = m_ww; end
                cs_cnt++;
                if (m_we) we_cnt++;
            end
            if (m_cc) begin
                cc_cnt++;
                if (cc_cyc == 0) cc_cyc = i;
                if (auto_drop) begin cpu_rstrobe = 1'b0; cpu_wstrobe = 1'b0; end
            end
            if (m_dr) begin
                dr_cnt++;
                if (dr_cyc == 0) dr_cyc = i;
                if (auto_drop) dbg_ce = 1'b0;
            end
            if (m_mis) begin
                mis_cnt++;
                if (mis_cyc == 0) mis_cyc = i;
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0]);
            n_tests++; if ({m_cs, m_we, m_cc, m_dr} !== 4'b0) begin n_fail++;
                $display("FAIL reset_flags dut%0d: got %b expected 0000", s*2, {m_cs, m_we, m_cc, m_dr}); end
            n_tests++; if ({m_crd, m_drd} !== 128'd0) begin n_fail++;
                $display("FAIL reset_rdata dut%0d: got %h expected 0", s*2, {m_crd, m_drd}); end
            n_tests++; if ({m_addr, m_wdata, m_ww} !== 130'd0) begin n_fail++;
                $display("FAIL reset_ram_bus dut%0d: got %h expected 0", s*2, {m_addr, m_wdata, m_ww}); end
        end
    endtask

    task automatic test_read_ws0();
        do_reset(1'b0);
        cpu_addr = 64'h10; cpu_write_width = 2'd0; cpu_rstrobe = 1'b1;
        run(6, 1'b1);
        n_tests++; if (cs_cnt !== 1) begin n_fail++; $display("FAIL rd0_cs_cycles: got %0d expected 1", cs_cnt); end
        n_tests++; if (cc_cyc !== 3) begin n_fail++; $display("FAIL rd0_latency: got %0d expected 3", cc_cyc); end
        n_tests++; if (cc_cnt !== 1) begin n_fail++; $display("FAIL rd0_pulses: got %0d expected 1", cc_cnt); end
        n_tests++; if (m_crd !== 64'hDEADBEEF_CAFEF00D) begin n_fail++;
            $display("FAIL rd0_rdata: got %h expected deadbeefcafef00d", m_crd); end
        n_tests++; if (we_cnt !== 0 || cs_addr !== 64'h10) begin n_fail++;
            $display("FAIL rd0_ram_bus: got we=%0d addr=%h expected we=0 addr=10", we_cnt, cs_addr); end
    endtask

    task automatic test_write_ws2();
        do_reset(1'b1);
        cpu_addr = 64'h20; cpu_wdata = 64'hAB; cpu_write_width = 2'd3; cpu_wstrobe = 1'b1;
        run(8, 1'b1);
        n_tests++; if (cs_cnt !== 3 || we_cnt !== 3) begin n_fail++;
            $display("FAIL wr2_cs_we: got cs=%0d we=%0d expected 3/3", cs_cnt, we_cnt); end
        n_tests++; if (cs_ww !== 2'd3 || cs_addr !== 64'h20 || cs_wdata !== 64'hAB) begin n_fail++;
            $display("FAIL wr2_ram_bus: got ww=%0d addr=%h wd=%h expected 3/20/ab", cs_ww, cs_addr, cs_wdata); end
        n_tests++; if (cc_cyc !== 5 || cc_cnt !== 1) begin n_fail++;
            $display("FAIL wr2_latency: got cyc=%0d n=%0d expected 5/1", cc_cyc, cc_cnt); end
        n_tests++; if (m_crd !== 64'd0) begin n_fail++; $display("FAIL wr2_rdata_hold: got %h expected 0", m_crd); end
    endtask

    task automatic test_rw_both();
        do_reset(1'b0);
        cpu_addr = 64'h10; cpu_wdata = 64'h55; cpu_rstrobe = 1'b1; cpu_wstrobe = 1'b1;
        run(5, 1'b1);
        n_tests++; if (we_cnt !== 1 || cc_cyc !== 3) begin n_fail++;
            $display("FAIL both_strobes_write: got we=%0d cyc=%0d expected 1/3", we_cnt, cc_cyc); end
        n_tests++; if (m_crd !== 64'd0) begin n_fail++; $display("FAIL both_strobes_rdata: got %h expected 0", m_crd); end
    endtask

    task automatic test_dbg_priority();
        do_reset(1'b0);
        dbg_halt = 1'b1; dbg_ce = 1'b1; dbg_addr = 64'h40;
        cpu_addr = 64'h10; cpu_rstrobe = 1'b1;
        run(10, 1'b1);
        n_tests++; if (dr_cyc !== 3 || cc_cyc !== 6) begin n_fail++;
            $display("FAIL prio_order: got dbg=%0d cpu=%0d expected 3/6", dr_cyc, cc_cyc); end
        n_tests++; if (cs_cnt !== 2 || dr_cnt !== 1 || cc_cnt !== 1) begin n_fail++;
            $display("FAIL prio_counts: got cs=%0d dr=%0d cc=%0d expected 2/1/1", cs_cnt, dr_cnt, cc_cnt); end
        n_tests++; if (m_drd !== 64'h12345678_00000040 || m_crd !== 64'hDEADBEEF_CAFEF00D) begin n_fail++;
            $display("FAIL prio_rdata: got dbg=%h cpu=%h expected 1234567800000040/deadbeefcafef00d", m_drd, m_crd); end
    endtask

    task automatic test_dbg_write();
        do_reset(1'b0);
        dbg_halt = 1'b1; dbg_ce = 1'b1; dbg_we = 1'b1; dbg_addr = 64'h48;
        dbg_wdata = 64'h0123_4567_89AB_CDEF; cpu_write_width = 2'd3;
        run(5, 1'b1);
        n_tests++; if (cs_ww !== 2'd0 || we_cnt !== 1 || cs_wdata !== 64'h0123_4567_89AB_CDEF) begin n_fail++;
            $display("FAIL dbg_wr_bus: got ww=%0d we=%0d wd=%h expected 0/1/0123456789abcdef", cs_ww, we_cnt, cs_wdata); end
        n_tests++; if (dr_cyc !== 3 || m_drd !== 64'd0) begin n_fail++;
            $display("FAIL dbg_wr_resp: got cyc=%0d rd=%h expected 3/0", dr_cyc, m_drd); end
    endtask

    task automatic test_dbg_no_halt();
        do_reset(1'b0);
        dbg_ce = 1'b1; dbg_addr = 64'h40;
        run(8, 1'b0);
        dbg_ce = 1'b0;
        n_tests++; if (cs_cnt !== 0 || dr_cnt !== 0) begin n_fail++;
            $display("FAIL dbg_no_halt: got cs=%0d dr=%0d expected 0/0", cs_cnt, dr_cnt); end
    endtask

    task automatic test_halt_mid_cpu();
        do_reset(1'b1);
        cpu_addr = 64'h10; cpu_rstrobe = 1'b1;
        @(negedge clk);
        dbg_halt = 1'b1; dbg_ce = 1'b1; dbg_addr = 64'h40;
        run(14, 1'b1);
        n_tests++; if (cc_cyc !== 4 || dr_cyc !== 9) begin n_fail++;
            $display("FAIL halt_mid_order: got cpu=%0d dbg=%0d expected 4/9", cc_cyc, dr_cyc); end
        n_tests++; if (cs_cnt !== 5 || m_crd !== 64'hDEADBEEF_CAFEF00D || m_drd !== 64'h12345678_00000040) begin n_fail++;
            $display("FAIL halt_mid_data: got cs=%0d cpu=%h dbg=%h expected 5/deadbeefcafef00d/1234567800000040", cs_cnt, m_crd, m_drd); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        cpu_addr = 64'h18; cpu_rstrobe = 1'b1;
        run(9, 1'b0);
        cpu_rstrobe = 1'b0;
        n_tests++; if (cc_cnt !== 3 || cc_cyc !== 3 || cs_cnt !== 3) begin n_fail++;
            $display("FAIL b2b_throughput: got cc=%0d first=%0d cs=%0d expected 3/3/3", cc_cnt, cc_cyc, cs_cnt); end
        n_tests++; if (m_crd !== 64'h12345678_00000018) begin n_fail++;
            $display("FAIL b2b_rdata: got %h expected 1234567800000018", m_crd); end
    endtask

    task automatic test_reset_mid_access();
        do_reset(1'b1);
        cpu_addr = 64'h10; cpu_rstrobe = 1'b1;
        run(6, 1'b1);
        cpu_addr = 64'h18; cpu_rstrobe = 1'b1;      // grant cycle
        @(negedge clk);                             // first ACCESS cycle
        @(negedge clk);                             // second ACCESS cycle
        n_tests++; if (m_cs !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_cs: got %b expected 1", m_cs); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if ({m_cs, m_we, m_cc, m_dr} !== 4'b0 || m_crd !== 64'd0 || m_addr !== 64'd0) begin n_fail++;
            $display("FAIL rstmid_outputs: got flags=%b rd=%h addr=%h expected 0", {m_cs, m_we, m_cc, m_dr}, m_crd, m_addr); end
        rst = 1'b0; cpu_rstrobe = 1'b0;
        run(6, 1'b0);
        n_tests++; if (cc_cnt !== 0 || cs_cnt !== 0) begin n_fail++;
            $display("FAIL rstmid_no_pulse: got cc=%0d cs=%0d expected 0/0", cc_cnt, cs_cnt); end
    endtask

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    task automatic test_misalign();
        do_reset(1'b0);
        cpu_addr = 64'h3; cpu_write_width = 2'd1; cpu_rstrobe = 1'b1;
        run(5, 1'b1);
        n_tests++; if (cs_cnt !== 0 || cc_cyc !== 2 || mis_cyc !== 2 || mis_cnt !== 1) begin n_fail++;
            $display("FAIL misalign_reject: got cs=%0d cc=%0d mis=%0d n=%0d expected 0/2/2/1", cs_cnt, cc_cyc, mis_cyc, mis_cnt); end
        cpu_addr = 64'h4; cpu_write_width = 2'd1; cpu_rstrobe = 1'b1;
        run(5, 1'b1);
        n_tests++; if (cs_cnt !== 1 || cc_cyc !== 3 || mis_cnt !== 0) begin n_fail++;
            $display("FAIL misalign_aligned: got cs=%0d cc=%0d mis=%0d expected 1/3/0", cs_cnt, cc_cyc, mis_cnt); end
    endtask
`endif

    initial begin
        sel2 = 1'b0; rst = 1'b1;
        cpu_addr = 64'd0; cpu_wdata = 64'd0; cpu_write_width = 2'd0;
        cpu_rstrobe = 1'b0; cpu_wstrobe = 1'b0;
        dbg_halt = 1'b0; dbg_addr = 64'd0; dbg_wdata = 64'd0; dbg_ce = 1'b0; dbg_we = 1'b0;
        test_reset();
        test_read_ws0();
        test_write_ws2();
        test_rw_both();
        test_dbg_priority();
        test_dbg_write();
        test_dbg_no_halt();
        test_halt_mid_cpu();
        test_back_to_back();
        test_reset_mid_access();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, extra RAM cycles per access (0-15).
REQ-002 SHALL have parameter ADDR_W, default 64, address width.
REQ-003 SHALL have the ports: clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have the ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have the ports: cpu_addr in ADDR_W; cpu_wdata in 64; cpu_rdata out 64; cpu_write_width in 2 (0=64b, 1=32b, 2=16b, 3=8b); cpu_rstrobe in 1; cpu_wstrobe in 1; cpu_cycle_complete out 1.
REQ-006 SHALL have the ports: dbg_halt in 1; dbg_addr in ADDR_W; dbg_wdata in 64; dbg_rdata out 64; dbg_ce in 1; dbg_we in 1; dbg_ready out 1.
REQ-007 SHALL have the ports: ram_cs out 1; ram_we out 1; ram_addr out ADDR_W; ram_wdata out 64; ram_write_width out 2; ram_rdata in 64, valid one cycle after a cs cycle.

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, plus a combined owner register (CPU or DBG).
REQ-009 In IDLE, debug request (dbg_ce) SHALL win when dbg_halt=1; otherwise a CPU strobe wins; with dbg_halt=0 dbg_ce SHALL be ignored.
REQ-010 cpu_rstrobe and cpu_wstrobe both high SHALL be treated as a write.
REQ-011 Grant SHALL latch addr, wdata, width, we of the winner; latched values drive ram_* for all of ACCESS.
REQ-012 ACCESS SHALL last WAIT_STATES+1 cycles with ram_cs=1, ram_we=latched we; counter counts down to 0 then enters RESP.
REQ-013 In RESP, ram_cs=0; ram_rdata SHALL be captured into cpu_rdata or dbg_rdata (per owner) for reads; writes leave rdata unchanged.
REQ-014 cpu_cycle_complete (CPU owner) or dbg_ready (DBG owner) SHALL pulse high exactly the cycle after RESP; the next request may be granted that same cycle.
REQ-015 Latency from grant to completion pulse SHALL be WAIT_STATES+3 cycles; back-to-back throughput one access per WAIT_STATES+3 cycles.
REQ-016 Requesters SHALL hold strobes level until completion; a strobe dropped mid-access SHALL NOT abort it.
REQ-017 Debug writes SHALL always use width 0 (64b).
REQ-018 dbg_halt asserted during a CPU access SHALL let that access complete; debug granted next IDLE.
REQ-019 rdata outputs SHALL hold last captured value until next read of same owner.

Reset
REQ-020 rst SHALL force IDLE, counter 0, owner CPU, ram_cs=0, ram_we=0, cpu_cycle_complete=0, dbg_ready=0, cpu_rdata=0, dbg_rdata=0, ram_addr=0, ram_wdata=0, ram_write_width=0.
REQ-021 rst mid-access SHALL abandon it with no completion pulse; ram_cs low the following cycle.

Configuration
REQ-022 Macro DMEM_ARB_ALIGN_CHECK_EN defined SHALL add output cpu_misalign (1 bit): a CPU request whose address is not aligned to its width SHALL skip ACCESS (no ram_cs), go directly to RESP, pulse cpu_cycle_complete and cpu_misalign together for one cycle.
REQ-023 Without DMEM_ARB_ALIGN_CHECK_EN, cpu_misalign SHALL not exist and all accesses proceed unchecked.

Structure
REQ-024 Shared package SHALL hold FSM state enum, owner enum, write-width encodings and WAIT_STATES max constant.
REQ-025 Alignment check SHALL be a sub-module dmem_align_chk (combinational addr+width -> misaligned flag), instantiated only under the macro.

Verification
REQ-026 WAIT_STATES=0, CPU read addr 0x10 with RAM returning 0xDEADBEEF_CAFEF00D -> ram_cs 1 cycle, cpu_cycle_complete 3 cycles after grant, cpu_rdata=0xDEADBEEF_CAFEF00D.
REQ-027 WAIT_STATES=2, CPU write 0x20 width 3 data 0xAB -> ram_cs/ram_we high 3 cycles, ram_write_width=3, completion 5 cycles after grant.
REQ-028 dbg_halt=1, dbg_ce and cpu_rstrobe same cycle -> debug granted first, dbg_ready pulse, CPU then served, cpu_cycle_complete follows.
REQ-029 dbg_halt=0, dbg_ce=1 alone -> no ram_cs, dbg_ready stays 0.
REQ-030 rst asserted in second ACCESS cycle (WAIT_STATES=2) -> ram_cs 0 next cycle, no completion pulse, all outputs at reset values.
REQ-031 With DMEM_ARB_ALIGN_CHECK_EN, CPU read addr 0x3 width 1 -> no ram_cs, cpu_misalign and cpu_cycle_complete pulse together; addr 0x4 width 1 -> normal access.
